// File: rtl/fixed_att_residual.sv
// fixed_att_residual
// -----------------------------------------------------------------------------
// Residual-add stage that sits after the fixed-point attention block.
// Residual tiles are parked in a circular tile FIFO while attention computes.
// Each attention tile is joined with the oldest buffered residual tile. The
// two tiles are aligned to a common fraction width and added. The sum is
// rescaled to the output format (floor on right shift) and saturated. The
// result is held in a single output register.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous, active-low reset
//   data_in_res[N]       residual tile (signed, IN_FRAC_WIDTH fraction bits)
//   data_in_res_valid    residual tile offered
//   data_in_res_ready    FIFO has room (depends only on the occupancy register)
//   data_in_att[N]       attention tile (signed, ATT_FRAC_WIDTH fraction bits)
//   data_in_att_valid    attention tile offered
//   data_in_att_ready    a residual is buffered and the output register can load
//   data_out[N]          registered sum tile (signed, OUT_FRAC_WIDTH fraction bits)
//   data_out_valid       data_out holds an unconsumed tile
//   data_out_ready       downstream accepts data_out
//   sat_flag             sticky: some element has clamped since reset
//
// Handshake: a tile moves on a port exactly when valid && ready are both high
// at a rising clock edge. A source holds its tile stable until that edge.
// data_out stays stable while data_out_valid && !data_out_ready. Tiles are
// paired strictly in arrival order.
// -----------------------------------------------------------------------------
module fixed_att_residual #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 1,
  parameter int ATT_WIDTH      = 8,
  parameter int ATT_FRAC_WIDTH = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 1,
  parameter int IN_PARALLELISM = 3,
  parameter int IN_SIZE        = 2,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in_res [IN_PARALLELISM*IN_SIZE],
  input  logic                        data_in_res_valid,
  output logic                        data_in_res_ready,
  input  logic signed [ATT_WIDTH-1:0] data_in_att [IN_PARALLELISM*IN_SIZE],
  input  logic                        data_in_att_valid,
  output logic                        data_in_att_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic                        sat_flag
);

  localparam int N       = IN_PARALLELISM * IN_SIZE;
  localparam int PW      = $clog2(FIFO_DEPTH);
  // Common fraction width and integer headroom of the aligned operands.
  localparam int F       = (IN_FRAC_WIDTH > ATT_FRAC_WIDTH) ? IN_FRAC_WIDTH : ATT_FRAC_WIDTH;
  localparam int IN_INT  = IN_WIDTH - IN_FRAC_WIDTH;
  localparam int ATT_INT = ATT_WIDTH - ATT_FRAC_WIDTH;
  localparam int MAX_INT = (IN_INT > ATT_INT) ? IN_INT : ATT_INT;
  // One extra bit so the add itself can never overflow.
  localparam int SUM_W   = MAX_INT + F + 1;
  // Only one of these two shifts is non-zero.
  localparam int RSH     = (OUT_FRAC_WIDTH < F) ? (F - OUT_FRAC_WIDTH) : 0;
  localparam int LSH     = (OUT_FRAC_WIDTH > F) ? (OUT_FRAC_WIDTH - F) : 0;
  // Wide enough for the left-shifted sum and for the output limits.
  localparam int EXT_W   = SUM_W + LSH + OUT_WIDTH;

  localparam logic [PW:0]             DEPTH_C = FIFO_DEPTH[PW:0];
  localparam logic signed [EXT_W-1:0] ONE_C   = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic signed [EXT_W-1:0] MAX_V   = (ONE_C <<< (OUT_WIDTH - 1)) - ONE_C;
  localparam logic signed [EXT_W-1:0] MIN_V   = -(ONE_C <<< (OUT_WIDTH - 1));

  // Residual tile FIFO
  logic signed [IN_WIDTH-1:0] mem [FIFO_DEPTH][N];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [PW:0]                count;

  logic push;
  logic pop;

  // Arithmetic datapath
  logic signed [SUM_W-1:0]     res_al  [N];
  logic signed [SUM_W-1:0]     att_al  [N];
  logic signed [SUM_W-1:0]     sum     [N];
  logic signed [EXT_W-1:0]     conv    [N];
  logic signed [OUT_WIDTH-1:0] sum_sat [N];
  logic                        any_clamp;

  assign data_in_res_ready = (count != DEPTH_C);
  assign data_in_att_ready = (count != '0) && (!data_out_valid || data_out_ready);
  assign push              = data_in_res_valid && data_in_res_ready;
  assign pop               = data_in_att_valid && data_in_att_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < N; i++) mem[wr_ptr][i] <= data_in_res[i];
    end
  end

  // Align, add, rescale, saturate. The read side sees the tile at rd_ptr
  // directly; a tile pushed this cycle is not visible until the next one.
  always_comb begin
    any_clamp = 1'b0;
    for (int i = 0; i < N; i++) begin
      res_al[i]  = SUM_W'(mem[rd_ptr][i]) <<< (F - IN_FRAC_WIDTH);
      att_al[i]  = SUM_W'(data_in_att[i]) <<< (F - ATT_FRAC_WIDTH);
      sum[i]     = res_al[i] + att_al[i];
      // Arithmetic right shift floors toward minus infinity.
      conv[i]    = (EXT_W'(sum[i]) >>> RSH) <<< LSH;
      sum_sat[i] = conv[i][OUT_WIDTH-1:0];
      if (conv[i] > MAX_V) begin
        sum_sat[i] = MAX_V[OUT_WIDTH-1:0];
        any_clamp  = 1'b1;
      end else if (conv[i] < MIN_V) begin
        sum_sat[i] = MIN_V[OUT_WIDTH-1:0];
        any_clamp  = 1'b1;
      end
    end
  end

  // Output register and sticky saturation flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
      for (int i = 0; i < N; i++) data_out[i] <= '0;
    end else begin
      if (pop) begin
        data_out_valid <= 1'b1;
        for (int i = 0; i < N; i++) data_out[i] <= sum_sat[i];
        if (any_clamp) sat_flag <= 1'b1;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_att_residual.sv
// tb_fixed_att_residual
// Exercises fixed_att_residual with default parameters, plus a second
// instance using OUT_FRAC_WIDTH=0 for the floor-rounding cases. A negedge
// scoreboard tracks the residual FIFO and the output register as queues.
// It checks handshake readiness, output validity, data and sat_flag every
// cycle. Scenario tasks add their own targeted checks.
module tb_fixed_att_residual;
  localparam int N          = 6;
  localparam int EW         = 8;
  localparam int W          = N * EW;
  localparam int FIFO_DEPTH = 16;
  localparam int IFR        = 1;
  localparam int AFR        = 1;
  localparam int FR         = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic [W-1:0]   res_tile = '0, att_tile = '0, out_tile;
  logic signed [EW-1:0] res_arr [N];
  logic signed [EW-1:0] att_arr [N];
  logic signed [EW-1:0] out_arr [N];
  logic res_valid = 1'b0, att_valid = 1'b0, out_ready = 1'b1;
  logic data_in_res_ready, data_in_att_ready, data_out_valid, sat_flag;

  // OUT_FRAC_WIDTH = 0 instance
  logic [W-1:0]   res0_tile = '0, att0_tile = '0, out0_tile;
  logic signed [EW-1:0] res0_arr [N];
  logic signed [EW-1:0] att0_arr [N];
  logic signed [EW-1:0] out0_arr [N];
  logic res0_valid = 1'b0, att0_valid = 1'b0;
  logic res0_ready, att0_ready, out0_valid, sat0_flag;

  always_comb begin
    out_tile  = '0;
    out0_tile = '0;
    for (int i = 0; i < N; i++) begin
      res_arr[i]           = res_tile[i*EW +: EW];
      att_arr[i]           = att_tile[i*EW +: EW];
      res0_arr[i]          = res0_tile[i*EW +: EW];
      att0_arr[i]          = att0_tile[i*EW +: EW];
      out_tile[i*EW +: EW]  = out_arr[i];
      out0_tile[i*EW +: EW] = out0_arr[i];
    end
  end

  fixed_att_residual u_dut (
    .clk(clk), .rst(rst),
    .data_in_res(res_arr), .data_in_res_valid(res_valid), .data_in_res_ready(data_in_res_ready),
    .data_in_att(att_arr), .data_in_att_valid(att_valid), .data_in_att_ready(data_in_att_ready),
    .data_out(out_arr), .data_out_valid(data_out_valid), .data_out_ready(out_ready),
    .sat_flag(sat_flag)
  );

  fixed_att_residual #(.OUT_FRAC_WIDTH(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .data_in_res(res0_arr), .data_in_res_valid(res0_valid), .data_in_res_ready(res0_ready),
    .data_in_att(att0_arr), .data_in_att_valid(att0_valid), .data_in_att_ready(att0_ready),
    .data_out(out0_arr), .data_out_valid(out0_valid), .data_out_ready(1'b1),
    .sat_flag(sat0_flag)
  );

  int checks = 0;
  int errors = 0;

  // Reference arithmetic: real-valued sum in units of 2^-F, floored to the
  // output resolution, clamped to the signed output range.
  function automatic logic [EW-1:0] ref_elem(input int r, input int a, input int of,
                                              output logic clamp);
    int fmax, s, d, q, maxv, minv;
    fmax = (IFR > AFR) ? IFR : AFR;
    s = r * (1 << (fmax - IFR)) + a * (1 << (fmax - AFR));
    if (of < fmax) begin
      d = 1 << (fmax - of);
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      s = q;
    end else begin
      s = s * (1 << (of - fmax));
    end
    maxv  = (1 << (EW - 1)) - 1;
    minv  = -(1 << (EW - 1));
    clamp = 1'b0;
    if (s > maxv) begin s = maxv; clamp = 1'b1; end
    if (s < minv) begin s = minv; clamp = 1'b1; end
    return EW'(s);
  endfunction

  function automatic logic [W-1:0] ref_tile(input logic [W-1:0] r, input logic [W-1:0] a,
                                            input int of, output logic clamp);
    logic [W-1:0] t;
    logic c;
    logic [EW-1:0] re, ae;
    t = '0;
    clamp = 1'b0;
    for (int i = 0; i < N; i++) begin
      re = r[i*EW +: EW];
      ae = a[i*EW +: EW];
      t[i*EW +: EW] = ref_elem(int'($signed(re)), int'($signed(ae)), of, c);
      clamp = clamp | c;
    end
    return t;
  endfunction

  function automatic logic [W-1:0] rand_tile();
    logic [W-1:0] t;
    for (int i = 0; i < N; i++) t[i*EW +: EW] = EW'($urandom_range(0, 255));
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] res_q[$];
  logic [W-1:0] exp_q[$];
  logic ov_m = 1'b0, sat_m = 1'b0, live = 1'b0;
  int   out_count = 0;
  logic m_rr, m_ar, m_rf, m_af, m_clamp;
  logic [W-1:0] m_r, m_e;

  always @(negedge clk) begin
    if (!rst) begin
      res_q.delete();
      exp_q.delete();
      ov_m  = 1'b0;
      sat_m = 1'b0;
      live  = 1'b1;
    end else if (live) begin
      m_rr = (res_q.size() < FIFO_DEPTH);
      m_ar = (res_q.size() > 0) && (!ov_m || out_ready);
      checks += 4;
      if (data_in_res_ready !== m_rr) begin
        errors++; $display("FAIL sb_res_ready got=%b exp=%b t=%0t", data_in_res_ready, m_rr, $time);
      end
      if (data_in_att_ready !== m_ar) begin
        errors++; $display("FAIL sb_att_ready got=%b exp=%b t=%0t", data_in_att_ready, m_ar, $time);
      end
      if (data_out_valid !== ov_m) begin
        errors++; $display("FAIL sb_out_valid got=%b exp=%b t=%0t", data_out_valid, ov_m, $time);
      end
      if (sat_flag !== sat_m) begin
        errors++; $display("FAIL sb_sat_flag got=%b exp=%b t=%0t", sat_flag, sat_m, $time);
      end
      if (ov_m) begin
        checks++;
        if (out_tile !== exp_q[0]) begin
          errors++; $display("FAIL sb_data_out got=%h exp=%h t=%0t", out_tile, exp_q[0], $time);
        end
      end
      m_rf = res_valid && m_rr;
      m_af = att_valid && m_ar;
      if (ov_m && out_ready) begin
        void'(exp_q.pop_front());
        ov_m = 1'b0;
        out_count++;
      end
      if (m_af) begin
        m_r = res_q.pop_front();
        m_e = ref_tile(m_r, att_tile, FR, m_clamp);
        exp_q.push_back(m_e);
        ov_m = 1'b1;
        if (m_clamp) sat_m = 1'b1;
      end
      if (m_rf) res_q.push_back(res_tile);
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put_res(input logic [W-1:0] t);
    logic fired;
    int n;
    res_tile = t; res_valid = 1'b1; n = 0;
    do begin
      @(negedge clk); fired = data_in_res_ready;
      tick(); n++;
    end while (!fired && n < 50);
    res_valid = 1'b0;
    checks++;
    if (!fired) begin errors++; $display("FAIL put_res_timeout got=0 exp=1"); end
  endtask

  task automatic put_att(input logic [W-1:0] t);
    logic fired;
    int n;
    att_tile = t; att_valid = 1'b1; n = 0;
    do begin
      @(negedge clk); fired = data_in_att_ready;
      tick(); n++;
    end while (!fired && n < 50);
    att_valid = 1'b0;
    checks++;
    if (!fired) begin errors++; $display("FAIL put_att_timeout got=0 exp=1"); end
  endtask

  task automatic run_traffic(input int n_res, input int n_att, input int res_pct,
                             input int att_pct, input int rdy_pct, output int cycles);
    int ri, ai;
    logic rf, af, res_hold, att_hold;
    ri = 0; ai = 0; cycles = 0; res_hold = 1'b0; att_hold = 1'b0;
    while ((ri < n_res || ai < n_att) && cycles < 2000) begin
      if (!res_hold) begin
        res_valid = (ri < n_res) && ($urandom_range(1, 100) <= res_pct);
        res_tile  = rand_tile();
      end
      if (!att_hold) begin
        att_valid = (ai < n_att) && ($urandom_range(1, 100) <= att_pct);
        att_tile  = rand_tile();
      end
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      @(negedge clk);
      rf = res_valid && data_in_res_ready;
      af = att_valid && data_in_att_ready;
      if (rf) ri++;
      if (af) ai++;
      res_hold = res_valid && !rf;
      att_hold = att_valid && !af;
      cycles++;
      tick();
    end
    res_valid = 1'b0;
    att_valid = 1'b0;
    checks++;
    if (ri != n_res || ai != n_att) begin
      errors++; $display("FAIL traffic_timeout got=%0d/%0d exp=%0d/%0d", ri, ai, n_res, n_att);
    end
  endtask

  task automatic drain();
    res_valid = 1'b0; att_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks += 4;
    if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_out_valid); end
    if (out_tile !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_tile); end
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    if (data_in_att_ready !== 1'b0) begin errors++; $display("FAIL reset_att_ready got=%b exp=0", data_in_att_ready); end
    rst = 1'b1;
    tick();
    checks++;
    if (data_in_res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready got=%b exp=1", data_in_res_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] r, a, e;
    r = {N{8'h0A}};
    a = {N{8'h06}};
    e = {N{8'h10}};
    out_ready = 1'b1;
    put_res(r);
    put_att(a);
    checks += 3;
    if (data_out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", data_out_valid); end
    if (out_tile !== e) begin errors++; $display("FAIL basic_sum got=%h exp=%h", out_tile, e); end
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b exp=0", sat_flag); end
    drain();
  endtask

  task automatic test_saturation();
    logic [W-1:0] r, e;
    for (int i = 0; i < N; i++) begin
      r[i*EW +: EW] = (i % 2 == 0) ? 8'h64 : 8'h9C;
      e[i*EW +: EW] = (i % 2 == 0) ? 8'h7F : 8'h80;
    end
    put_res(r);
    put_att(r);
    checks += 2;
    if (out_tile !== e) begin errors++; $display("FAIL sat_clamp got=%h exp=%h", out_tile, e); end
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_set got=%b exp=1", sat_flag); end
    put_res({N{8'h0A}});
    put_att({N{8'h06}});
    drain();
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", sat_flag); end
  endtask

  task automatic test_format();
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      res0_tile[i*EW +: EW] = (i % 2 == 0) ? 8'h03 : 8'hFD;
      e[i*EW +: EW]         = (i % 2 == 0) ? 8'h01 : 8'hFE;
    end
    att0_tile  = '0;
    res0_valid = 1'b1;
    tick();
    res0_valid = 1'b0;
    att0_valid = 1'b1;
    tick();
    att0_valid = 1'b0;
    checks += 3;
    if (out0_valid !== 1'b1) begin errors++; $display("FAIL fmt_valid got=%b exp=1", out0_valid); end
    if (out0_tile !== e) begin errors++; $display("FAIL fmt_floor got=%h exp=%h", out0_tile, e); end
    if (sat0_flag !== 1'b0) begin errors++; $display("FAIL fmt_sat got=%b exp=0", sat0_flag); end
    tick();
  endtask

  task automatic test_full_wrap();
    int cyc, base;
    out_ready = 1'b1;
    run_traffic(FIFO_DEPTH, 0, 100, 0, 100, cyc);
    checks++;
    if (data_in_res_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", data_in_res_ready); end
    res_valid = 1'b1;
    res_tile  = rand_tile();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (data_in_res_ready !== 1'b0) begin errors++; $display("FAIL full_hold got=%b exp=0", data_in_res_ready); end
      tick();
    end
    res_valid = 1'b0;
    base = out_count;
    run_traffic(40, 56, 100, 100, 100, cyc);
    checks++;
    if (cyc != 56) begin errors++; $display("FAIL wrap_throughput got=%0d exp=56", cyc); end
    drain();
    checks += 2;
    if (out_count - base != 56) begin errors++; $display("FAIL wrap_count got=%0d exp=56", out_count - base); end
    if (data_in_att_ready !== 1'b0) begin errors++; $display("FAIL empty_att_ready got=%b exp=0", data_in_att_ready); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] snap, r, a, e;
    logic c;
    int fires, cyc;
    r = rand_tile();
    a = rand_tile();
    e = ref_tile(r, a, FR, c);
    out_ready = 1'b0;
    put_res(r);
    put_att(a);
    snap = out_tile;
    checks++;
    if (snap !== e) begin errors++; $display("FAIL bp_first got=%h exp=%h", snap, e); end
    fires = 0;
    for (int k = 0; k < 5; k++) begin
      res_valid = 1'b1; res_tile = rand_tile();
      att_valid = 1'b1; att_tile = rand_tile();
      @(negedge clk);
      checks += 3;
      if (data_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", data_out_valid); end
      if (out_tile !== snap) begin errors++; $display("FAIL bp_stable got=%h exp=%h", out_tile, snap); end
      if (data_in_att_ready !== 1'b0) begin errors++; $display("FAIL bp_att_ready got=%b exp=0", data_in_att_ready); end
      if (data_in_res_ready) fires++;
      tick();
    end
    res_valid = 1'b0; att_valid = 1'b0;
    checks++;
    if (fires != 5) begin errors++; $display("FAIL bp_res_accept got=%0d exp=5", fires); end
    run_traffic(0, 5, 0, 100, 50, cyc);
    drain();
  endtask

  task automatic test_random();
    int cyc;
    run_traffic(60, 60, 70, 60, 60, cyc);
    drain();
    checks++;
    if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained got=%b exp=0", data_out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r, a, e;
    logic c;
    int cyc;
    run_traffic(5, 1, 100, 100, 0, cyc);
    checks++;
    if (data_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", data_out_valid); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    checks += 3;
    if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", data_out_valid); end
    if (data_in_att_ready !== 1'b0) begin errors++; $display("FAIL mid_att_ready got=%b exp=0", data_in_att_ready); end
    if (out_tile !== '0) begin errors++; $display("FAIL mid_data got=%h exp=0", out_tile); end
    repeat (3) begin
      tick();
      checks++;
      if (data_out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_emit got=%b exp=0", data_out_valid); end
    end
    r = rand_tile();
    a = rand_tile();
    e = ref_tile(r, a, FR, c);
    put_res(r);
    put_att(a);
    checks += 2;
    if (out_tile !== e) begin errors++; $display("FAIL mid_new_sum got=%h exp=%h", out_tile, e); end
    if (sat_flag !== c) begin errors++; $display("FAIL mid_sat got=%b exp=%b", sat_flag, c); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_format();
    test_full_wrap();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
